// File: rtl/i2s_receiver.sv
// i2s_receiver
// I2S slave receiver. BCLK, LRCLK and SDATA are oversampled by clk; no logic
// runs on BCLK. Standard I2S framing: LRCLK changes one bit before the MSB,
// so the bit sampled on the first rising BCLK edge with a new LRCLK is the
// LSB of the previous word. Each committed word raises a one-cycle strobe
// for its channel, and word_err rises with it when the bit count was wrong.
//
// Handshake: left_valid / right_valid are single-cycle strobes with no
// ready. data_left / data_right change on the same clk edge that raises the
// strobe and hold until the next commit on that channel, so the word may be
// taken while the strobe is high or at any later time. word_err is only
// ever high together with one of the two strobes.
module i2s_receiver #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  BCLK,
  input  logic                  LRCLK,
  input  logic                  SDATA,
  output logic [DATA_WIDTH-1:0] data_left,
  output logic [DATA_WIDTH-1:0] data_right,
  output logic                  left_valid,
  output logic                  right_valid,
  output logic                  word_err,
  output logic                  RightNLeft,
  output logic [1:0]            dbg_state
);

  // Counter wide enough to hold DATA_WIDTH itself (saturation value).
  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_RX    = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Input conditioning flops.
  logic bclk_s1_q, bclk_s1_d;
  logic bclk_s2_q, bclk_s2_d;
  logic bclk_d_q, bclk_d_d;
  logic lrclk_s1_q, lrclk_s1_d;
  logic lrclk_s2_q, lrclk_s2_d;
  logic sdata_s1_q, sdata_s1_d;
  logic sdata_s2_q, sdata_s2_d;

  // Word assembly state.
  logic                  ws_prev_q, ws_prev_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  rnl_q, rnl_d;

  // Registered outputs.
  logic [DATA_WIDTH-1:0] data_left_q, data_left_d;
  logic [DATA_WIDTH-1:0] data_right_q, data_right_d;
  logic                  left_valid_q, left_valid_d;
  logic                  right_valid_q, right_valid_d;
  logic                  word_err_q, word_err_d;

  // Decoded stream events.
  logic                  bit_tick;
  logic                  ws;
  logic                  bit_in;
  logic                  ws_change;
  logic [DATA_WIDTH-1:0] shreg_ins;

  // Rising edge of synchronized BCLK marks one serial bit; LRCLK and SDATA
  // are taken from their own synchronizers on that cycle.
  always_comb begin
    bit_tick  = bclk_s2_q & ~bclk_d_q;
    ws        = lrclk_s2_q;
    bit_in    = sdata_s2_q;
    ws_change = bit_tick & (ws != ws_prev_q);
  end

  // Synchronizer chains and BCLK edge-detect delay.
  always_comb begin
    bclk_s1_d  = BCLK;
    bclk_s2_d  = bclk_s1_q;
    bclk_d_d   = bclk_s2_q;
    lrclk_s1_d = LRCLK;
    lrclk_s2_d = lrclk_s1_q;
    sdata_s1_d = SDATA;
    sdata_s2_d = sdata_s1_q;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: enable low always falls back to IDLE; alignment waits
  // for the first word boundary seen after enable.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_ALIGN;
      end
      ST_ALIGN: begin
        if (!enable)        state_d = ST_IDLE;
        else if (ws_change) state_d = ST_RX;
      end
      ST_RX: begin
        if (!enable) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: channel indicator is only meaningful while receiving.
  always_comb begin
    RightNLeft = (state_q == ST_RX) ? rnl_q : 1'b0;
    dbg_state  = state_q;
  end

  // Current word with the present bit inserted at its MSB-first position;
  // bits beyond DATA_WIDTH fall off because no index matches.
  always_comb begin
    shreg_ins = shreg_q;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (cnt_q == CW'(DATA_WIDTH - 1 - i)) shreg_ins[i] = bit_in;
    end
  end

  // Word assembly and commit datapath.
  always_comb begin
    ws_prev_d     = ws_prev_q;
    cnt_d         = cnt_q;
    shreg_d       = shreg_q;
    rnl_d         = rnl_q;
    data_left_d   = data_left_q;
    data_right_d  = data_right_q;
    left_valid_d  = 1'b0;
    right_valid_d = 1'b0;
    word_err_d    = 1'b0;

    // ws_prev follows the sampled word select in every state.
    if (bit_tick) ws_prev_d = ws;

    if (enable && state_q == ST_ALIGN && ws_change) begin
      // Boundary found: the in-flight partial word is thrown away.
      cnt_d   = '0;
      shreg_d = '0;
      rnl_d   = ws;
    end else if (enable && state_q == ST_RX && bit_tick) begin
      if (ws_change) begin
        // Final bit of the ws_prev word: commit it, then start afresh.
        if (ws_prev_q) begin
          data_right_d  = shreg_ins;
          right_valid_d = 1'b1;
        end else begin
          data_left_d  = shreg_ins;
          left_valid_d = 1'b1;
        end
        // Final count is cnt_q + 1 (unsaturated); only DATA_WIDTH is clean.
        word_err_d = (cnt_q != CW'(DATA_WIDTH - 1));
        cnt_d      = '0;
        shreg_d    = '0;
        rnl_d      = ws;
      end else begin
        shreg_d = shreg_ins;
        if (cnt_q < CW'(DATA_WIDTH)) cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Datapath registers; reset overrides any commit in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      bclk_s1_q     <= 1'b0;
      bclk_s2_q     <= 1'b0;
      bclk_d_q      <= 1'b0;
      lrclk_s1_q    <= 1'b0;
      lrclk_s2_q    <= 1'b0;
      sdata_s1_q    <= 1'b0;
      sdata_s2_q    <= 1'b0;
      ws_prev_q     <= 1'b0;
      cnt_q         <= '0;
      shreg_q       <= '0;
      rnl_q         <= 1'b0;
      data_left_q   <= '0;
      data_right_q  <= '0;
      left_valid_q  <= 1'b0;
      right_valid_q <= 1'b0;
      word_err_q    <= 1'b0;
    end else begin
      bclk_s1_q     <= bclk_s1_d;
      bclk_s2_q     <= bclk_s2_d;
      bclk_d_q      <= bclk_d_d;
      lrclk_s1_q    <= lrclk_s1_d;
      lrclk_s2_q    <= lrclk_s2_d;
      sdata_s1_q    <= sdata_s1_d;
      sdata_s2_q    <= sdata_s2_d;
      ws_prev_q     <= ws_prev_d;
      cnt_q         <= cnt_d;
      shreg_q       <= shreg_d;
      rnl_q         <= rnl_d;
      data_left_q   <= data_left_d;
      data_right_q  <= data_right_d;
      left_valid_q  <= left_valid_d;
      right_valid_q <= right_valid_d;
      word_err_q    <= word_err_d;
    end
  end

  // Drive ports straight from their registers.
  always_comb begin
    data_left   = data_left_q;
    data_right  = data_right_q;
    left_valid  = left_valid_q;
    right_valid = right_valid_q;
    word_err    = word_err_q;
  end

endmodule

// File: tb/tb_i2s_receiver.sv
// tb_i2s_receiver
// Drives an I2S stream at BCLK = clk/8 and checks committed words through an
// expected-response queue popped by an independent output monitor.
module tb_i2s_receiver;

  localparam int DW = 16;

  logic          clk;
  logic          rst;
  logic          enable;
  logic          BCLK;
  logic          LRCLK;
  logic          SDATA;
  logic [DW-1:0] data_left;
  logic [DW-1:0] data_right;
  logic          left_valid;
  logic          right_valid;
  logic          word_err;
  logic          RightNLeft;
  logic [1:0]    dbg_state;

  // Expected commit: {channel, word_err, data}
  logic [DW+1:0] exp_q[$];
  time           t_q[$];

  int n_vec = 0;
  int n_err = 0;

  i2s_receiver #(.DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .BCLK       (BCLK),
    .LRCLK      (LRCLK),
    .SDATA      (SDATA),
    .data_left  (data_left),
    .data_right (data_right),
    .left_valid (left_valid),
    .right_valid(right_valid),
    .word_err   (word_err),
    .RightNLeft (RightNLeft),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- compare helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Bits with SDATA=0 while the receiver is not expected to commit.
  task automatic send_idle(input int nbits, input logic lr);
    for (int k = 0; k < nbits; k++) begin
      BCLK = 1'b0; LRCLK = lr; SDATA = 1'b0;
      #40;
      BCLK = 1'b1;
      #40;
    end
  endtask

  // One I2S word, MSB first. The LSB goes out with LRCLK already at nxt.
  // exp_data/exp_err are the hand-computed commit, pushed when the LSB is
  // driven if commit=1. en_at/dis_at/rst_at act before bit k (-1 = never).
  task automatic send_word(input logic ch, input logic [31:0] value, input int nbits,
                           input logic nxt, input bit commit,
                           input logic [DW-1:0] exp_data, input logic exp_err,
                           input int en_at, input int dis_at, input int rst_at);
    for (int k = 0; k < nbits; k++) begin
      if (k == en_at)  enable = 1'b1;
      if (k == dis_at) enable = 1'b0;
      BCLK  = 1'b0;
      LRCLK = (k == nbits - 1) ? nxt : ch;
      SDATA = value[nbits-1-k];
      if (k == nbits - 1 && commit) begin
        exp_q.push_back({ch, exp_err, exp_data});
        t_q.push_back($time + 40);
      end
      if (k == rst_at) begin
        rst = 1'b1; enable = 1'b0;
        #10;
        rst = 1'b0;
        #30;
      end else begin
        #40;
      end
      BCLK = 1'b1;
      #40;
      if (commit && k == nbits / 2) check("right_n_left", RightNLeft, ch);
    end
  endtask

  // Plain word that is expected to commit normally.
  task automatic word(input logic ch, input logic [31:0] value, input int nbits,
                      input logic [DW-1:0] exp_data, input logic exp_err);
    send_word(ch, value, nbits, ~ch, 1'b1, exp_data, exp_err, -1, -1, -1);
  endtask

  // Word that must not produce a commit.
  task automatic word_nc(input logic ch, input logic [31:0] value,
                         input int en_at, input int dis_at, input int rst_at);
    send_word(ch, value, DW, ~ch, 1'b0, '0, 1'b0, en_at, dis_at, rst_at);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [DW+1:0] e;
    time           ts;
    if (left_valid && right_valid) check("both_valid", 32'd1, 32'd0);
    if (word_err && !(left_valid || right_valid)) check("lone_word_err", 32'd1, 32'd0);
    if (left_valid || right_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {left_valid, right_valid}, 32'd0);
      end else begin
        e  = exp_q.pop_front();
        ts = t_q.pop_front();
        check("channel", right_valid, e[DW+1]);
        check("word_err", word_err, e[DW]);
        check(right_valid ? "data_right" : "data_left",
              right_valid ? data_right : data_left, e[DW-1:0]);
        check("latency_ok", (($time - ts) >= 25 && ($time - ts) <= 45), 32'd1);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; enable = 1'b0; BCLK = 1'b0; LRCLK = 1'b0; SDATA = 1'b0;

    // Reset with random pins for 3 cycles.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      BCLK = 1'($urandom_range(0, 1)); LRCLK = 1'($urandom_range(0, 1));
      SDATA = 1'($urandom_range(0, 1)); enable = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #2;
    rst = 1'b0; enable = 1'b0; BCLK = 1'b0; LRCLK = 1'b0; SDATA = 1'b0;
    @(negedge clk);
    check("rst_data_left", data_left, 0);
    check("rst_data_right", data_right, 0);
    check("rst_right_n_left", RightNLeft, 0);
    check("rst_state", dbg_state, 0);
    for (int i = 0; i < 2; i++) begin
      check("rst_no_pulse", {left_valid, right_valid, word_err}, 0);
      @(negedge clk);
    end
    @(posedge clk); #2;

    // Nominal: idle on right channel, alignment word discarded, two frames.
    send_idle(3, 1'b1);
    enable = 1'b1;
    word_nc(1'b1, 32'h5555, -1, -1, -1);
    word(1'b0, 32'hA5C3, 16, 16'hA5C3, 1'b0);
    word(1'b1, 32'h1234, 16, 16'h1234, 1'b0);
    word(1'b0, 32'hA5C3, 16, 16'hA5C3, 1'b0);
    word(1'b1, 32'h1234, 16, 16'h1234, 1'b0);

    // Short left word, long right word, then clean words again.
    word(1'b0, 32'hABC,   12, 16'hABC0, 1'b1);
    word(1'b1, 32'hABCDE, 20, 16'hABCD, 1'b1);
    word(1'b0, 32'h1357,  16, 16'h1357, 1'b0);
    word(1'b1, 32'h2468,  16, 16'h2468, 1'b0);

    // Enable rises at bit 7 of a left word: first commit is the right word.
    enable = 1'b0;
    send_idle(0, 1'b0);
    word_nc(1'b0, 32'h1111, 7, -1, -1);
    word(1'b1, 32'h7E81, 16, 16'h7E81, 1'b0);

    // Abort by enable at bit 9: no commit, outputs hold, realign needed.
    word_nc(1'b0, 32'h2222, -1, 9, -1);
    check("abort_hold_left", data_left, 16'h1357);
    check("abort_hold_right", data_right, 16'h7E81);
    check("abort_rnl_idle", RightNLeft, 0);
    enable = 1'b1;
    word_nc(1'b1, 32'h3333, -1, -1, -1);
    word(1'b0, 32'h4444, 16, 16'h4444, 1'b0);

    // Abort by 1-cycle reset at bit 9: outputs cleared, realign needed.
    word_nc(1'b1, 32'h5A5A, -1, -1, 9);
    check("rst_abort_left", data_left, 0);
    check("rst_abort_right", data_right, 0);
    check("rst_abort_state", dbg_state, 0);
    enable = 1'b1;
    word_nc(1'b0, 32'h9999, -1, -1, -1);
    word(1'b1, 32'h0F0F, 16, 16'h0F0F, 1'b0);

    // Continuous stream of the loopback pattern.
    for (int f = 0; f < 3; f++) begin
      word(1'b0, 32'h5A5A, 16, 16'h5A5A, 1'b0);
      word(1'b1, 32'h3C3C, 16, 16'h3C3C, 1'b0);
    end
    send_idle(2, 1'b0);

    // Drain with a bounded wait.
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("final_left", data_left, 16'h5A5A);
    check("final_right", data_right, 16'h3C3C);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
